// File: rtl/pl_sysref_pkg.sv
// pl_sysref_pkg: shared state encoding and default sizes for the SYSREF qualifier
package pl_sysref_pkg;
  typedef enum logic [2:0] {IDLE, ACQUIRE, MEASURE, VERIFY, LOCKED} state_t;
  localparam int DEF_PERIOD_W = 16;
  localparam int DEF_LOCK_CNT = 4;
  localparam int ERR_CNT_W    = 8;
endpackage

// File: rtl/pl_sysref_period_meas.sv
// pl_sysref_period_meas: SYSREF rising-edge detector and saturating period counter
module pl_sysref_period_meas #(
  parameter int PERIOD_W = 16
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_sysref,
  input  logic                i_run,
  output logic                o_level,
  output logic                o_rise,
  output logic [PERIOD_W-1:0] o_period,
  output logic                o_sat
);
  logic                r_s1, r_s2;
  logic [PERIOD_W-1:0] r_cnt;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1  <= 1'b0;
      r_s2  <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_s1  <= i_sysref;
      r_s2  <= r_s1;
      r_cnt <= (!i_run || o_rise) ? '0 : (&r_cnt) ? r_cnt : r_cnt + PERIOD_W'(1);
    end
  end
  assign o_level  = r_s1;
  assign o_rise   = r_s1 & ~r_s2;
  assign o_period = r_cnt + PERIOD_W'(1);
  assign o_sat    = i_run & (&r_cnt) & ~o_rise;
endmodule

// File: rtl/pl_sysref_capture_qual.sv
// pl_sysref_capture_qual: qualifies board SYSREF by period lock and gates it to the retimer
module pl_sysref_capture_qual
  import pl_sysref_pkg::*;
#(
  parameter int PERIOD_W = DEF_PERIOD_W,
  parameter int LOCK_CNT = DEF_LOCK_CNT,
  parameter int TOL      = 0
) (
  input  logic                 pl_clk_buf,
  input  logic                 pl_rst_n,
  input  logic                 sysref_in,
  input  logic                 sysref_en,
  input  logic                 clr_err,
  output logic                 pl_sysref_captured,
  output logic                 sysref_locked,
  output logic [PERIOD_W-1:0]  sysref_period,
  output logic                 sysref_err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 timeout
);
  state_t              r_state, w_next;
  logic                w_level, w_rise, w_sat, w_run, w_match, w_set_err, w_set_to;
  logic [PERIOD_W-1:0] w_period, w_diff;
  logic [3:0]          r_match_cnt;

  pl_sysref_period_meas #(.PERIOD_W(PERIOD_W)) u_meas (
    .i_clk    (pl_clk_buf),
    .i_rst_n  (pl_rst_n),
    .i_sysref (sysref_in),
    .i_run    (w_run),
    .o_level  (w_level),
    .o_rise   (w_rise),
    .o_period (w_period),
    .o_sat    (w_sat)
  );

  // sysref_period doubles as the reference the new period is judged against
  assign w_diff    = (w_period >= sysref_period) ? w_period - sysref_period : sysref_period - w_period;
  assign w_match   = w_diff <= PERIOD_W'(TOL);
  assign w_set_err = sysref_en & w_rise & ~w_match & (r_state == LOCKED);
  assign w_set_to  = sysref_en & w_sat;

  always_ff @(posedge pl_clk_buf or negedge pl_rst_n) begin
    if (!pl_rst_n) r_state <= IDLE;
    else           r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (!sysref_en) w_next = IDLE;
    else if (w_sat) w_next = ACQUIRE;
    else begin
      case (r_state)
        IDLE:    w_next = ACQUIRE;
        ACQUIRE: w_next = w_rise ? MEASURE : ACQUIRE;
        MEASURE: w_next = w_rise ? VERIFY : MEASURE;
        VERIFY:  w_next = (w_rise && w_match && r_match_cnt == 4'(LOCK_CNT - 1)) ? LOCKED : VERIFY;
        LOCKED:  w_next = w_set_err ? VERIFY : LOCKED;
        default: w_next = IDLE;
      endcase
    end
  end

  always_comb begin
    w_run         = (r_state == MEASURE) || (r_state == VERIFY) || (r_state == LOCKED);
    sysref_locked = r_state == LOCKED;
  end

  // a new error or timeout in the same cycle as clr_err takes priority over the clear
  always_ff @(posedge pl_clk_buf or negedge pl_rst_n) begin
    if (!pl_rst_n) begin
      pl_sysref_captured <= 1'b0;
      r_match_cnt        <= '0;
      sysref_period      <= '0;
      sysref_err         <= 1'b0;
      err_cnt            <= '0;
      timeout            <= 1'b0;
    end else begin
      pl_sysref_captured <= w_level & sysref_locked & sysref_en;
      r_match_cnt        <= (sysref_en && r_state == VERIFY) ?
                            (w_rise ? (w_match ? r_match_cnt + 4'd1 : 4'd0) : r_match_cnt) : 4'd0;
      if (sysref_en && w_rise && (r_state == MEASURE ||
          ((r_state == VERIFY || r_state == LOCKED) && !w_match)))
        sysref_period <= w_period;
      sysref_err <= w_set_err | (sysref_err & ~clr_err);
      timeout    <= w_set_to | (timeout & ~clr_err);
      err_cnt    <= w_set_err ? (clr_err ? ERR_CNT_W'(1) : (&err_cnt) ? err_cnt : err_cnt + ERR_CNT_W'(1)) :
                    clr_err ? '0 : err_cnt;
    end
  end
endmodule

// File: tb/tb_pl_sysref_capture_qual.sv
// tb_pl_sysref_capture_qual: three DUT variants (default, TOL=1, PERIOD_W=8) against a timestamp model
module tb_pl_sysref_capture_qual;
  logic clk = 1'b0;
  logic rst_n, en, sin, clr;
  logic [2:0]       cap_v, lock_v, err_v, to_v;
  logic [2:0][15:0] per_v;
  logic [2:0][7:0]  errc_v;
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pl_sysref_capture_qual #(.PERIOD_W(16), .LOCK_CNT(4), .TOL(0)) u0 (
    .pl_clk_buf(clk), .pl_rst_n(rst_n), .sysref_in(sin), .sysref_en(en), .clr_err(clr),
    .pl_sysref_captured(cap_v[0]), .sysref_locked(lock_v[0]), .sysref_period(per_v[0]),
    .sysref_err(err_v[0]), .err_cnt(errc_v[0]), .timeout(to_v[0]));
  pl_sysref_capture_qual #(.PERIOD_W(16), .LOCK_CNT(4), .TOL(1)) u1 (
    .pl_clk_buf(clk), .pl_rst_n(rst_n), .sysref_in(sin), .sysref_en(en), .clr_err(clr),
    .pl_sysref_captured(cap_v[1]), .sysref_locked(lock_v[1]), .sysref_period(per_v[1]),
    .sysref_err(err_v[1]), .err_cnt(errc_v[1]), .timeout(to_v[1]));
  pl_sysref_capture_qual #(.PERIOD_W(8), .LOCK_CNT(4), .TOL(0)) u2 (
    .pl_clk_buf(clk), .pl_rst_n(rst_n), .sysref_in(sin), .sysref_en(en), .clr_err(clr),
    .pl_sysref_captured(cap_v[2]), .sysref_locked(lock_v[2]), .sysref_period(per_v[2][7:0]),
    .sysref_err(err_v[2]), .err_cnt(errc_v[2]), .timeout(to_v[2]));
  assign per_v[2][15:8] = '0;

  // model: rise timestamps, a match streak and a reference period per instance
  int  mw[3]   = '{16, 16, 8};
  int  mtol[3] = '{0, 1, 0};
  bit  m_armed[3], m_started[3], m_have_ref[3], m_locked[3], m_err[3], m_to[3], m_cap[3];
  int  m_streak[3], m_tlast[3], m_ref[3], m_errc[3];
  bit  d1, d2;
  int  now = 0;

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_armed[k] = 0; m_started[k] = 0; m_have_ref[k] = 0; m_locked[k] = 0;
      m_err[k] = 0; m_to[k] = 0; m_cap[k] = 0; m_streak[k] = 0; m_ref[k] = 0; m_errc[k] = 0;
    end
    d1 = 0; d2 = 0;
  endtask

  task automatic model_step();
    bit rise, sat, set_err, set_to;
    int el, p, dv;
    rise = d1 && !d2;
    for (int k = 0; k < 3; k++) begin
      el = now - m_tlast[k];
      sat = m_started[k] && !rise && el >= (1 << mw[k]);
      set_err = 0; set_to = 0;
      m_cap[k] = d1 && m_locked[k] && en;
      if (!en) begin
        m_armed[k] = 0; m_started[k] = 0; m_have_ref[k] = 0; m_locked[k] = 0; m_streak[k] = 0;
      end else if (!m_armed[k]) m_armed[k] = 1;
      else if (sat) begin
        set_to = 1; m_started[k] = 0; m_have_ref[k] = 0; m_locked[k] = 0; m_streak[k] = 0;
      end else if (rise) begin
        if (!m_started[k]) m_started[k] = 1;
        else begin
          p = el % (1 << mw[k]);
          dv = p - m_ref[k];
          if (dv < 0) dv = -dv;
          if (!m_have_ref[k]) begin
            m_ref[k] = p; m_have_ref[k] = 1; m_streak[k] = 0;
          end else if (dv <= mtol[k]) begin
            if (!m_locked[k]) begin
              m_streak[k]++;
              if (m_streak[k] == 4) m_locked[k] = 1;
            end
          end else begin
            set_err = m_locked[k]; m_ref[k] = p; m_streak[k] = 0; m_locked[k] = 0;
          end
        end
        m_tlast[k] = now;
      end
      m_err[k]  = set_err || (m_err[k] && !clr);
      m_to[k]   = set_to || (m_to[k] && !clr);
      m_errc[k] = set_err ? (clr ? 1 : (m_errc[k] == 255 ? 255 : m_errc[k] + 1)) : clr ? 0 : m_errc[k];
    end
    d2 = d1; d1 = sin; now++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic compare(input int k);
    chk($sformatf("u%0d.locked", k), lock_v[k], m_locked[k]);
    chk($sformatf("u%0d.captured", k), cap_v[k], m_cap[k]);
    chk($sformatf("u%0d.period", k), per_v[k], m_ref[k]);
    chk($sformatf("u%0d.err", k), err_v[k], m_err[k]);
    chk($sformatf("u%0d.err_cnt", k), errc_v[k], m_errc[k]);
    chk($sformatf("u%0d.timeout", k), to_v[k], m_to[k]);
  endtask

  task automatic chk_zero(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk({tag, "_locked"}, lock_v[k], 0);
      chk({tag, "_captured"}, cap_v[k], 0);
      chk({tag, "_period"}, per_v[k], 0);
      chk({tag, "_err"}, err_v[k], 0);
      chk({tag, "_err_cnt"}, errc_v[k], 0);
      chk({tag, "_timeout"}, to_v[k], 0);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) compare(k);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // mode 1: output tracks input two edges late; 2: lock rises one cycle after this rise;
  // 3: gating already dropped shortly after this rise
  task automatic pulse(input int per, input int hi, input int clr_idx, input int mode);
    for (int i = 0; i < per; i++) begin
      sin = (i < hi);
      clr = (i == clr_idx);
      tick();
      if (mode == 1) chk("cap_follow", cap_v[0], (i >= 1 && i - 1 < hi));
      if (mode == 2 && i < 2) chk("lock_edge", lock_v[0], (i == 1));
      if (mode == 3 && i == 4) begin
        chk("jit_cap_low", cap_v[0], 0);
        chk("jit_unlocked", lock_v[0], 0);
      end
    end
    clr = 0;
  endtask

  task automatic pulses(input int n, input int per);
    for (int i = 0; i < n; i++) pulse(per, per / 2, -1, 0);
  endtask

  initial begin
    int per, hi;
    rst_n = 0; en = 0; sin = 0; clr = 0;
    model_reset();
    #3;
    chk_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1;
    // lock at period 32
    en = 1;
    ticks(3);
    pulses(5, 32);
    for (int k = 0; k < 3; k++) chk("pre_lock", lock_v[k], 0);
    pulse(32, 16, -1, 2);
    for (int k = 0; k < 3; k++) begin
      chk("locked", lock_v[k], 1);
      chk("lock_period", per_v[k], 32);
    end
    pulse(32, 16, -1, 1);
    // one long period while locked
    pulse(33, 16, -1, 0);
    pulse(32, 16, -1, 3);
    chk("jit_err", err_v[0], 1);
    chk("jit_err_cnt", errc_v[0], 1);
    chk("jit_period", per_v[0], 33);
    chk("tol_no_err", errc_v[1], 0);
    pulses(4, 32);
    chk("relock_not_yet", lock_v[0], 0);
    chk("ref_back", per_v[0], 32);
    pulses(1, 32);
    chk("relocked", lock_v[0], 1);
    // tolerance with alternating periods
    en = 0; clr = 1;
    tick();
    clr = 0;
    ticks(2);
    chk("clr_err_flag", err_v[0], 0);
    chk("clr_err_cnt", errc_v[0], 0);
    en = 1;
    ticks(3);
    for (int j = 0; j < 8; j++) pulse((j % 2) ? 33 : 32, 16, -1, 0);
    chk("tol_locked", lock_v[1], 1);
    chk("tol_err_cnt", errc_v[1], 0);
    chk("tol0_unlocked", lock_v[0], 0);
    // timeout on the 8-bit counter
    pulses(8, 20);
    chk("w8_locked", lock_v[2], 1);
    chk("w8_period", per_v[2], 20);
    sin = 0;
    ticks(200);
    chk("w8_no_to_yet", to_v[2], 0);
    ticks(100);
    chk("w8_timeout", to_v[2], 1);
    chk("w8_unlocked", lock_v[2], 0);
    chk("w16_still_locked", lock_v[0], 1);
    chk("w16_no_timeout", to_v[0], 0);
    clr = 1;
    tick();
    clr = 0;
    chk("to_cleared", to_v[2], 0);
    // disable mid-pulse
    en = 0;
    ticks(2);
    en = 1;
    ticks(3);
    pulses(6, 32);
    sin = 1;
    ticks(5);
    for (int k = 0; k < 3; k++) chk("cap_high", cap_v[k], 1);
    en = 0;
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("dis_cap", cap_v[k], 0);
      chk("dis_lock", lock_v[k], 0);
      chk("dis_period", per_v[k], 32);
    end
    sin = 0; en = 1;
    ticks(3);
    pulses(5, 32);
    chk("reen_not_yet", lock_v[0], 0);
    pulse(32, 16, -1, 2);
    // clear colliding with a new mismatch
    pulse(33, 16, -1, 0);
    pulses(6, 32);
    chk("pre_coll_cnt", errc_v[0], 1);
    pulse(33, 16, -1, 0);
    pulse(32, 16, 1, 0);
    chk("coll_err", err_v[0], 1);
    chk("coll_err_cnt", errc_v[0], 1);
    // asynchronous reset mid-pulse
    pulses(6, 32);
    chk("pre_rst_locked", lock_v[0], 1);
    sin = 1;
    ticks(4);
    chk("pre_rst_cap", cap_v[0], 1);
    #2 rst_n = 0;
    #1 chk_zero("async_rst");
    #2 rst_n = 1;
    model_reset();
    sin = 0;
    ticks(3);
    // randomized periods, duty, clears and brief disables
    for (int p = 0; p < 60; p++) begin
      per = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 300) : 31 + $urandom_range(0, 2);
      hi = $urandom_range(1, per - 1);
      for (int i = 0; i < per; i++) begin
        sin = (i < hi);
        clr = ($urandom_range(0, 40) == 0);
        en = ($urandom_range(0, 999) != 0);
        tick();
      end
    end
    clr = 0; en = 1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
